// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the host-side memory loader: command codes,
// FSM state encodings and the header word layout.
package mem_loader_pkg;

    typedef enum logic [1:0] {
        CMD_LOAD_I = 2'd0,
        CMD_LOAD_D = 2'd1,
        CMD_DUMP_D = 2'd2,
        CMD_RUN    = 2'd3
    } cmd_e;

    typedef enum logic [3:0] {
        ST_HDR,
        ST_LOAD_I,
        ST_LOAD_D_LO,
        ST_LOAD_D_HI,
        ST_DUMP_RD,
        ST_DUMP_WAIT,
        ST_DUMP_LO,
        ST_DUMP_HI,
        ST_RUN,
        ST_RUN_ACK
    } state_e;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_LO,
        SER_HI
    } ser_e;

    // Header layout: [31:30] cmd, [29:16] base word index, [15:0] count.
    typedef struct packed {
        cmd_e        cmd;
        logic [13:0] base;
        logic [15:0] count;
    } header_t;

    localparam logic [31:0] RUN_DONE = 32'h0000_0D0E;

endpackage

// File: rtl/mem_loader_if.sv
// Host stream plus instruction/data memory ext ports driven by the loader.
// The master modport is the loader side; slave is the host/memory side.
interface mem_loader_if #(
    parameter int ADDR_W = 64
) ();
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;
    logic              m_valid;
    logic              m_ready;
    logic [31:0]       m_data;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_wen;
    logic              imem_ren;
    logic [31:0]       imem_wdata;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_wen;
    logic              dmem_ren;
    logic [63:0]       dmem_wdata;
    logic [63:0]       dmem_rdata;
    logic              cpu_enable;
    logic              busy;

    modport master (
        input  s_valid, s_data, m_ready, dmem_rdata,
        output s_ready, m_valid, m_data,
               imem_addr, imem_wen, imem_ren, imem_wdata,
               dmem_addr, dmem_wen, dmem_ren, dmem_wdata,
               cpu_enable, busy
    );

    modport slave (
        output s_valid, s_data, m_ready, dmem_rdata,
        input  s_ready, m_valid, m_data,
               imem_addr, imem_wen, imem_ren, imem_wdata,
               dmem_addr, dmem_wen, dmem_ren, dmem_wdata,
               cpu_enable, busy
    );
endinterface

// File: rtl/mem_loader_out_ser.sv
// Captures one 64-bit data-memory word and emits it as two 32-bit stream
// words, low half first, under valid/ready.
module mem_loader_out_ser
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [63:0] data_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        done_o
);

    ser_e        phase_q, phase_d;
    logic [63:0] data_q, data_d;

    // NOTE: next-state values get defaults before the case so no path leaves them unassigned (no latches).
    always_comb begin
        phase_d = phase_q;
        data_d  = data_q;
        done_o  = 1'b0;
        unique case (phase_q)
            SER_IDLE: begin
                if (load_i) begin
                    data_d  = data_i;
                    phase_d = SER_LO;
                end
            end
            SER_LO:   if (ready_i) phase_d = SER_HI;
            SER_HI: begin
                if (ready_i) begin
                    phase_d = SER_IDLE;
                    done_o  = 1'b1;
                end
            end
            default:  phase_d = SER_IDLE;
        endcase
    end

    assign valid_o = (phase_q != SER_IDLE);
    assign data_o  = (phase_q == SER_HI) ? data_q[63:32] :
                     (phase_q == SER_LO) ? data_q[31:0]  : 32'h0;

    // NOTE: state registers use non-blocking assignments; reset is synchronous and drops any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= SER_IDLE;
            data_q  <= '0;
        end else begin
            phase_q <= phase_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Host-side initiator: decodes header/payload words to load instruction and
// data memory, dump data memory back to the host, and gate the CPU for N cycles.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_loader_if.master  bus
);

    state_e            state_q, state_d;
    logic [15:0]       idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [31:0]       lo_q, lo_d;
    logic [1:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              imem_wen_q, imem_wen_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [63:0]       dmem_wdata_q, dmem_wdata_d;
    logic              dmem_wen_q, dmem_wen_d;
    logic              dmem_ren_q, dmem_ren_d;
    logic              cpu_en_q, cpu_en_d;

    logic              s_ready, s_fire, m_valid, m_fire;
    logic              ser_load, ser_valid, ser_done;
    logic [31:0]       ser_data;
    header_t           hdr;

    assign hdr     = header_t'(bus.s_data);
    assign s_ready = (state_q inside {ST_HDR, ST_LOAD_I, ST_LOAD_D_LO, ST_LOAD_D_HI});
    assign s_fire  = bus.s_valid && s_ready;
    assign m_valid = ser_valid || (state_q == ST_RUN_ACK);
    assign m_fire  = m_valid && bus.m_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        lo_d         = lo_q;
        wait_d       = wait_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        imem_wen_d   = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_wen_d   = 1'b0;
        dmem_ren_d   = 1'b0;
        cpu_en_d     = 1'b0;
        ser_load     = 1'b0;

        unique case (state_q)
            ST_HDR: begin
                if (s_fire) begin
                    idx_d = {2'b00, hdr.base};
                    cnt_d = hdr.count;
                    // A zero count stays in HDR so no port sees any activity.
                    if (hdr.count != 16'd0) begin
                        unique case (hdr.cmd)
                            CMD_LOAD_I: state_d = ST_LOAD_I;
                            CMD_LOAD_D: state_d = ST_LOAD_D_LO;
                            CMD_DUMP_D: state_d = ST_DUMP_RD;
                            CMD_RUN: begin
                                state_d  = ST_RUN;
                                cpu_en_d = 1'b1;
                            end
                            default:    state_d = ST_HDR;
                        endcase
                    end
                end
            end
            ST_LOAD_I: begin
                if (s_fire) begin
                    imem_wen_d   = 1'b1;
                    imem_addr_d  = ADDR_W'({idx_q, 2'b00});
                    imem_wdata_d = bus.s_data;
                    idx_d        = idx_q + 16'd1;
                    cnt_d        = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = ST_HDR;
                end
            end
            ST_LOAD_D_LO: begin
                if (s_fire) begin
                    lo_d    = bus.s_data;
                    state_d = ST_LOAD_D_HI;
                end
            end
            ST_LOAD_D_HI: begin
                if (s_fire) begin
                    dmem_wen_d   = 1'b1;
                    dmem_addr_d  = ADDR_W'({idx_q, 3'b000});
                    dmem_wdata_d = {bus.s_data, lo_q};
                    idx_d        = idx_q + 16'd1;
                    cnt_d        = cnt_q - 16'd1;
                    state_d      = (cnt_q == 16'd1) ? ST_HDR : ST_LOAD_D_LO;
                end
            end
            ST_DUMP_RD: begin
                dmem_ren_d  = 1'b1;
                dmem_addr_d = ADDR_W'({idx_q, 3'b000});
                wait_d      = 2'd0;
                state_d     = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                // The registered ren is visible one cycle after DUMP_RD, so rdata lands RD_LAT cycles later.
                if (wait_q == 2'(RD_LAT)) begin
                    ser_load = 1'b1;
                    state_d  = ST_DUMP_LO;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_DUMP_LO: if (m_fire) state_d = ST_DUMP_HI;
            ST_DUMP_HI: begin
                if (ser_done) begin
                    idx_d   = idx_q + 16'd1;
                    cnt_d   = cnt_q - 16'd1;
                    state_d = (cnt_q == 16'd1) ? ST_HDR : ST_DUMP_RD;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = ST_RUN_ACK;
                else                cpu_en_d = 1'b1;
            end
            ST_RUN_ACK: if (m_fire) state_d = ST_HDR;
            default:    state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HDR;
            idx_q        <= '0;
            cnt_q        <= '0;
            lo_q         <= '0;
            wait_q       <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            imem_wen_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wen_q   <= 1'b0;
            dmem_ren_q   <= 1'b0;
            cpu_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            lo_q         <= lo_d;
            wait_q       <= wait_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            imem_wen_q   <= imem_wen_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_ren_q   <= dmem_ren_d;
            cpu_en_q     <= cpu_en_d;
        end
    end

    mem_loader_out_ser u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ser_load),
        .data_i  (bus.dmem_rdata),
        .ready_i (bus.m_ready),
        .valid_o (ser_valid),
        .data_o  (ser_data),
        .done_o  (ser_done)
    );

    assign bus.s_ready    = s_ready;
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = (state_q == ST_RUN_ACK) ? RUN_DONE : ser_data;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wen   = imem_wen_q;
    assign bus.imem_ren   = 1'b0;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wen   = dmem_wen_q;
    assign bus.dmem_ren   = dmem_ren_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.cpu_enable = cpu_en_q;
    assign bus.busy       = (state_q != ST_HDR);

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: two instances (RD_LAT=1 and 2) share the host
// stimulus; negedge monitors log memory-port activity and readback words.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [31:0] s_data;
    logic        m_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_loader_if #(.ADDR_W(64)) bus0 ();
    mem_loader_if #(.ADDR_W(64)) bus1 ();

    assign bus0.s_valid = s_valid;
    assign bus0.s_data  = s_data;
    assign bus0.m_ready = m_ready;
    assign bus1.s_valid = s_valid;
    assign bus1.s_data  = s_data;
    assign bus1.m_ready = m_ready;

    mem_loader #(.ADDR_W(64), .RD_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_loader #(.ADDR_W(64), .RD_LAT(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Data memory models: rdata is valid only in the exact latency cycle, garbage otherwise.
    localparam logic [63:0] GARBAGE = 64'hEEEE_EEEE_EEEE_EEEE;
    logic [63:0] mem0 [0:15];
    logic [63:0] mem1 [0:15];
    logic [63:0] rd0, rd1, pipe1;

    always @(posedge clk) begin
        if (bus0.dmem_wen) mem0[bus0.dmem_addr[6:3]] <= bus0.dmem_wdata;
        rd0 <= bus0.dmem_ren ? mem0[bus0.dmem_addr[6:3]] : GARBAGE;
        if (bus1.dmem_wen) mem1[bus1.dmem_addr[6:3]] <= bus1.dmem_wdata;
        pipe1 <= bus1.dmem_ren ? mem1[bus1.dmem_addr[6:3]] : GARBAGE;
        rd1   <= pipe1;
    end
    assign bus0.dmem_rdata = rd0;
    assign bus1.dmem_rdata = rd1;

    logic [95:0]  ilog0 [$];
    logic [127:0] dlog0 [$];
    logic [63:0]  rlog0 [$];
    logic [31:0]  mlog0 [$];
    logic [31:0]  mlog1 [$];
    int en_cycles0 = 0, busy_cycles0 = 0, mutex_err0 = 0;
    int stall_seen0 = 0, stall_bad0 = 0, stall_seen1 = 0, stall_bad1 = 0;
    logic stall0 = 1'b0, stall1 = 1'b0;
    logic [31:0] held0, held1;

    always @(negedge clk) begin
        if (bus0.imem_wen === 1'b1) ilog0.push_back({bus0.imem_addr, bus0.imem_wdata});
        if (bus0.dmem_wen === 1'b1) dlog0.push_back({bus0.dmem_addr, bus0.dmem_wdata});
        if (bus0.dmem_ren === 1'b1) rlog0.push_back(bus0.dmem_addr);
        if (bus0.m_valid === 1'b1 && bus0.m_ready === 1'b1) mlog0.push_back(bus0.m_data);
        if (bus1.m_valid === 1'b1 && bus1.m_ready === 1'b1) mlog1.push_back(bus1.m_data);
        if (bus0.cpu_enable === 1'b1) en_cycles0 <= en_cycles0 + 1;
        if (bus0.busy === 1'b1) busy_cycles0 <= busy_cycles0 + 1;
        if ((bus0.cpu_enable === 1'b1 && (bus0.imem_wen | bus0.dmem_wen | bus0.dmem_ren) === 1'b1)
            || bus0.imem_ren !== 1'b0)
            mutex_err0 <= mutex_err0 + 1;
        if (rst === 1'b1) begin
            stall0 <= 1'b0;
            stall1 <= 1'b0;
        end else begin
            if (stall0) begin
                stall_seen0 <= stall_seen0 + 1;
                if (bus0.m_valid !== 1'b1 || bus0.m_data !== held0) stall_bad0 <= stall_bad0 + 1;
            end
            if (stall1) begin
                stall_seen1 <= stall_seen1 + 1;
                if (bus1.m_valid !== 1'b1 || bus1.m_data !== held1) stall_bad1 <= stall_bad1 + 1;
            end
            stall0 <= (bus0.m_valid === 1'b1 && bus0.m_ready !== 1'b1);
            stall1 <= (bus1.m_valid === 1'b1 && bus1.m_ready !== 1'b1);
            held0  <= bus0.m_data;
            held1  <= bus1.m_data;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one word; waits counts cycles the loader held s_ready low.
    task automatic send(input logic [31:0] d, output int waits);
        waits   = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (bus0.s_ready !== 1'b1 && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: word %h not accepted after %0d cycles", d, waits);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus0.s_ready, bus0.busy, bus0.m_valid, bus0.cpu_enable, bus0.imem_wen,
             bus0.imem_ren, bus0.dmem_wen, bus0.dmem_ren} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 10000000",
                     {bus0.s_ready, bus0.busy, bus0.m_valid, bus0.cpu_enable, bus0.imem_wen,
                      bus0.imem_ren, bus0.dmem_wen, bus0.dmem_ren});
        end
        checks++;
        if ({bus0.imem_addr, bus0.dmem_addr, bus0.imem_wdata, bus0.m_data} !== '0 ||
            bus0.dmem_wdata !== 64'h0) begin
            failures++;
            $display("FAIL reset_data: imem_addr %h dmem_addr %h m_data %h expected 0",
                     bus0.imem_addr, bus0.dmem_addr, bus0.m_data);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        cycles(1);
    endtask

    task automatic test_load_i;
        logic [95:0] exp [3];
        int b = ilog0.size();
        int w, wt = 0;
        exp[0] = {64'h10, 32'hAAAA_0001};
        exp[1] = {64'h14, 32'hBBBB_0002};
        exp[2] = {64'h18, 32'hCCCC_0003};
        send(32'h0004_0003, w); wt += w;
        send(32'hAAAA_0001, w); wt += w;
        send(32'hBBBB_0002, w); wt += w;
        send(32'hCCCC_0003, w); wt += w;
        cycles(2);
        checks++;
        if (wt !== 0) begin
            failures++;
            $display("FAIL load_i_ready: stalled %0d cycles expected 0", wt);
        end
        checks++;
        if (ilog0.size() - b !== 3) begin
            failures++;
            $display("FAIL load_i_count: got %0d writes expected 3", ilog0.size() - b);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ilog0[b + k] !== exp[k]) begin
                    failures++;
                    $display("FAIL load_i_write%0d: got %h expected %h", k, ilog0[b + k], exp[k]);
                end
            end
        end
        checks++;
        if (bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL load_i_idle: busy %b expected 0", bus0.busy);
        end
    endtask

    task automatic test_load_d;
        int b = dlog0.size();
        int ib = ilog0.size();
        int w;
        send(32'h4002_0001, w);
        send(32'h1111_1111, w);
        send(32'h2222_2222, w);
        send(32'h4003_0001, w);
        send(32'h0BAD_F00D, w);
        send(32'hDEAD_BEEF, w);
        cycles(2);
        checks++;
        if (dlog0.size() - b !== 2 || ilog0.size() !== ib) begin
            failures++;
            $display("FAIL load_d_count: dmem writes %0d expected 2, imem writes %0d expected 0",
                     dlog0.size() - b, ilog0.size() - ib);
        end else begin
            checks++;
            if (dlog0[b] !== {64'h10, 64'h2222_2222_1111_1111}) begin
                failures++;
                $display("FAIL load_d_word0: got %h expected 10/2222222211111111", dlog0[b]);
            end
            checks++;
            if (dlog0[b + 1] !== {64'h18, 64'hDEAD_BEEF_0BAD_F00D}) begin
                failures++;
                $display("FAIL load_d_word1: got %h expected 18/deadbeef0badf00d", dlog0[b + 1]);
            end
        end
    endtask

    task automatic test_dump;
        logic [31:0] exp [4];
        int b0 = mlog0.size();
        int b1 = mlog1.size();
        int rb = rlog0.size();
        int s0 = stall_seen0, s1 = stall_seen1;
        int w;
        bit done = 1'b0;
        exp[0] = 32'h1111_1111; exp[1] = 32'h2222_2222;
        exp[2] = 32'h0BAD_F00D; exp[3] = 32'hDEAD_BEEF;
        m_ready = 1'b0;
        send(32'h8002_0002, w);
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk);
            #1 m_ready = ~m_ready;
            if (mlog0.size() - b0 >= 4 && mlog1.size() - b1 >= 4 &&
                bus0.busy === 1'b0 && bus1.busy === 1'b0) done = 1'b1;
        end
        m_ready = 1'b0;
        cycles(2);
        checks++;
        if (!done || mlog0.size() - b0 !== 4 || mlog1.size() - b1 !== 4) begin
            failures++;
            $display("FAIL dump_count: lat1 %0d lat2 %0d words expected 4 each",
                     mlog0.size() - b0, mlog1.size() - b1);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (mlog0[b0 + k] !== exp[k] || mlog1[b1 + k] !== exp[k]) begin
                    failures++;
                    $display("FAIL dump_word%0d: lat1 %h lat2 %h expected %h",
                             k, mlog0[b0 + k], mlog1[b1 + k], exp[k]);
                end
            end
        end
        checks++;
        if (rlog0.size() - rb !== 2 || rlog0[rb] !== 64'h10 || rlog0[rb + 1] !== 64'h18) begin
            failures++;
            $display("FAIL dump_reads: %0d reads, expected 2 at 0x10,0x18", rlog0.size() - rb);
        end
        checks++;
        if (stall_seen0 == s0 || stall_seen1 == s1 || stall_bad0 !== 0 || stall_bad1 !== 0) begin
            failures++;
            $display("FAIL dump_stall: stalls %0d/%0d unstable %0d/%0d expected >0 and 0",
                     stall_seen0 - s0, stall_seen1 - s1, stall_bad0, stall_bad1);
        end
    endtask

    task automatic test_run;
        logic [7:0] en_pat, mv_pat;
        int ib = ilog0.size(), db = dlog0.size(), rb = rlog0.size(), mb = mlog0.size();
        int w;
        m_ready = 1'b0;
        send(32'hC000_0005, w);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            en_pat[7 - k] = bus0.cpu_enable;
            mv_pat[7 - k] = bus0.m_valid;
        end
        checks++;
        if (en_pat !== 8'b1111_1000) begin
            failures++;
            $display("FAIL run_enable: got %b expected 11111000", en_pat);
        end
        checks++;
        if (mv_pat !== 8'b0000_0111 || bus0.m_data !== 32'h0000_0D0E) begin
            failures++;
            $display("FAIL run_token: valid %b data %h expected 00000111 / 00000d0e", mv_pat, bus0.m_data);
        end
        checks++;
        if (ilog0.size() !== ib || dlog0.size() !== db || rlog0.size() !== rb) begin
            failures++;
            $display("FAIL run_strobes: imem %0d dmem %0d reads %0d expected none",
                     ilog0.size() - ib, dlog0.size() - db, rlog0.size() - rb);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        cycles(1);
        m_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (mlog0.size() - mb !== 1 || mlog0[mb] !== 32'h0000_0D0E || bus0.m_valid !== 1'b0 ||
            bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL run_ack: %0d words, m_valid %b busy %b expected 1 token then idle",
                     mlog0.size() - mb, bus0.m_valid, bus0.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_count;
        int ib = ilog0.size(), db = dlog0.size(), rb = rlog0.size(), mb = mlog0.size();
        int eb = en_cycles0, bb = busy_cycles0;
        int w, wt = 0;
        m_ready = 1'b1;
        send(32'h0004_0000, w); wt += w;
        send(32'h4004_0000, w); wt += w;
        send(32'h8004_0000, w); wt += w;
        send(32'hC004_0000, w); wt += w;
        cycles(4);
        m_ready = 1'b0;
        checks++;
        if (wt !== 0 || busy_cycles0 !== bb || en_cycles0 !== eb) begin
            failures++;
            $display("FAIL zero_state: stalls %0d busy %0d enable %0d expected 0/0/0",
                     wt, busy_cycles0 - bb, en_cycles0 - eb);
        end
        checks++;
        if (ilog0.size() !== ib || dlog0.size() !== db || rlog0.size() !== rb || mlog0.size() !== mb) begin
            failures++;
            $display("FAIL zero_ports: imem %0d dmem %0d reads %0d words %0d expected none",
                     ilog0.size() - ib, dlog0.size() - db, rlog0.size() - rb, mlog0.size() - mb);
        end
    endtask

    task automatic test_wrap;
        int b = ilog0.size();
        int w;
        send(32'h3FFF_0002, w);
        send(32'h1234_5678, w);
        send(32'h9ABC_DEF0, w);
        cycles(2);
        checks++;
        if (ilog0.size() - b !== 2) begin
            failures++;
            $display("FAIL wrap_count: got %0d writes expected 2", ilog0.size() - b);
        end else begin
            checks++;
            if (ilog0[b] !== {64'hFFFC, 32'h1234_5678} || ilog0[b + 1] !== {64'h1_0000, 32'h9ABC_DEF0}) begin
                failures++;
                $display("FAIL wrap_addr: got %h %h expected fffc/12345678 10000/9abcdef0",
                         ilog0[b], ilog0[b + 1]);
            end
        end
    endtask

    task automatic test_reset_mid_load;
        int db = dlog0.size(), ib = ilog0.size();
        int w;
        send(32'h4005_0002, w);
        send(32'h5555_5555, w);
        send(32'h6666_6666, w);
        send(32'h7777_7777, w);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus0.s_ready, bus0.busy, bus0.dmem_wen, bus0.cpu_enable} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_load_state: s_ready/busy/wen/en %b expected 1000",
                     {bus0.s_ready, bus0.busy, bus0.dmem_wen, bus0.cpu_enable});
        end
        @(posedge clk);
        #1;
        send(32'h0001_0001, w);
        send(32'h0F0F_0F0F, w);
        send(32'h4006_0001, w);
        send(32'h0000_0001, w);
        send(32'h0000_0002, w);
        cycles(2);
        checks++;
        if (dlog0.size() - db !== 2 || ilog0.size() - ib !== 1) begin
            failures++;
            $display("FAIL rst_load_count: dmem %0d imem %0d expected 2/1",
                     dlog0.size() - db, ilog0.size() - ib);
        end else begin
            checks++;
            if (dlog0[db] !== {64'h28, 64'h6666_6666_5555_5555} ||
                dlog0[db + 1] !== {64'h30, 64'h0000_0002_0000_0001}) begin
                failures++;
                $display("FAIL rst_load_dmem: got %h %h", dlog0[db], dlog0[db + 1]);
            end
            checks++;
            if (ilog0[ib] !== {64'h4, 32'h0F0F_0F0F}) begin
                failures++;
                $display("FAIL rst_load_imem: got %h expected 4/0f0f0f0f", ilog0[ib]);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int eb, mb;
        int w;
        m_ready = 1'b1;
        send(32'hC000_000A, w);
        cycles(3);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus0.cpu_enable, bus0.busy, bus0.m_valid, bus0.s_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL rst_run_state: en/busy/m_valid/s_ready %b expected 0001",
                     {bus0.cpu_enable, bus0.busy, bus0.m_valid, bus0.s_ready});
        end
        @(posedge clk);
        #1;
        eb = en_cycles0;
        mb = mlog0.size();
        cycles(12);
        m_ready = 1'b0;
        checks++;
        if (en_cycles0 !== eb || mlog0.size() !== mb) begin
            failures++;
            $display("FAIL rst_run_after: enable %0d words %0d expected 0/0",
                     en_cycles0 - eb, mlog0.size() - mb);
        end
    endtask

    initial begin
        test_reset();
        test_load_i();
        test_load_d();
        test_dump();
        test_run();
        test_zero_count();
        test_wrap();
        test_reset_mid_load();
        test_reset_mid_run();
        checks++;
        if (mutex_err0 !== 0) begin
            failures++;
            $display("FAIL mutex: %0d cycles with cpu_enable and a strobe or imem_ren set, expected 0",
                     mutex_err0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
